// File: rtl/sync_fifo_pkg.sv
// Shared types and width helpers for the sync FIFO family.
package sync_fifo_pkg;

  typedef enum logic {FIFO_MODE_STD, FIFO_MODE_FWFT} fifo_mode_e;

  function automatic int fifo_ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, STD/FWFT read mode, programmable
// almost-full/almost-empty thresholds, occupancy output and sticky error flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         FIFO_WIDTH = 8,
  parameter fifo_mode_e FIFO_MODE  = FIFO_MODE_STD,
  localparam int        PTR_W      = fifo_ptr_width(FIFO_DEPTH),
  localparam int        CNT_W      = fifo_cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wren,
  input  logic [FIFO_WIDTH-1:0] wrdata,
  input  logic                  rden,
  output logic [FIFO_WIDTH-1:0] rddata,
  output logic                  rdvalid,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  input  logic                  clr_err,
  output logic [CNT_W-1:0]      level,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FIFO_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc;

  assign full         = (level == CNT_FULL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);

  // No bypass: full blocks writes and empty blocks reads regardless of the other side.
  assign wr_acc = wren & ~full;
  assign rd_acc = rden & ~empty;

  sync_fifo_mem #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (FIFO_WIDTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wrdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A new error event outranks a simultaneous clear.
      if (wren && full)      overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (rden && empty)     underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  generate
    if (FIFO_MODE == FIFO_MODE_FWFT) begin : g_fwft
      assign rddata  = empty ? '0 : mem_rdata;
      assign rdvalid = ~empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (!rstn) begin
          rddata  <= '0;
          rdvalid <= 1'b0;
        end else begin
          rdvalid <= rd_acc;
          if (rd_acc) rddata <= mem_rdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: DEPTH=4 STD instance and DEPTH=5 FWFT instance, shared clock/reset.
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic       s_wren, s_rden, s_clr;
  logic [7:0] s_wrdata, s_rddata;
  logic [2:0] s_af, s_ae, s_level;
  logic       s_rdvalid, s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;

  logic       f_wren, f_rden, f_clr;
  logic [7:0] f_wrdata, f_rddata;
  logic [2:0] f_af, f_ae, f_level;
  logic       f_rdvalid, f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;

  int checks = 0;
  int failures = 0;

  sync_fifo_prog #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_MODE(FIFO_MODE_STD)) u_std (
    .clk(clk), .rstn(rstn), .wren(s_wren), .wrdata(s_wrdata), .rden(s_rden),
    .rddata(s_rddata), .rdvalid(s_rdvalid), .af_thresh(s_af), .ae_thresh(s_ae),
    .clr_err(s_clr), .level(s_level), .full(s_full), .almost_full(s_afull),
    .empty(s_empty), .almost_empty(s_aempty), .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_prog #(.FIFO_DEPTH(5), .FIFO_WIDTH(8), .FIFO_MODE(FIFO_MODE_FWFT)) u_fwft (
    .clk(clk), .rstn(rstn), .wren(f_wren), .wrdata(f_wrdata), .rden(f_rden),
    .rddata(f_rddata), .rdvalid(f_rdvalid), .af_thresh(f_af), .ae_thresh(f_ae),
    .clr_err(f_clr), .level(f_level), .full(f_full), .almost_full(f_afull),
    .empty(f_empty), .almost_empty(f_aempty), .overflow(f_ovf), .underflow(f_unf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_wren = 0; s_rden = 0; s_clr = 0; s_wrdata = 0; s_af = 3'd3; s_ae = 3'd1;
    f_wren = 0; f_rden = 0; f_clr = 0; f_wrdata = 0; f_af = 3'd4; f_ae = 3'd1;
    tick(); tick();
    rstn = 1'b1;
    // {level, full, empty, almost_full, almost_empty, overflow, underflow, rdvalid}
    checks++;
    if ({s_level, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf, s_rdvalid} !== 10'b000_0101000) begin
      failures++;
      $display("FAIL reset_std_status got=%b want=%b",
               {s_level, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf, s_rdvalid}, 10'b000_0101000);
    end
    checks++;
    if (s_rddata !== 8'h00) begin failures++; $display("FAIL reset_std_rddata got=%h want=00", s_rddata); end
    checks++;
    if ({f_level, f_rdvalid, f_rddata, f_empty} !== {3'd0, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_fwft got level=%0d rdvalid=%b rddata=%h empty=%b want 0 0 00 1",
               f_level, f_rdvalid, f_rddata, f_empty);
    end
    s_af = 3'd0; #1;
    checks++;
    if (s_afull !== 1'b1) begin failures++; $display("FAIL af_thresh_zero got=%b want=1", s_afull); end
    s_af = 3'd3;
  endtask

  task automatic test_fill();
    logic [7:0] wd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       af_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       fu_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      s_wren = 1; s_wrdata = wd[i];
      tick();
      checks++;
      if (s_level !== 3'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d want=%0d", i, s_level, i + 1); end
      checks++;
      if (s_afull !== af_exp[i]) begin failures++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, s_afull, af_exp[i]); end
      checks++;
      if (s_full !== fu_exp[i]) begin failures++; $display("FAIL fill_full[%0d] got=%b want=%b", i, s_full, fu_exp[i]); end
    end
    s_wren = 0;
    checks++;
    if (s_aempty !== 1'b0) begin failures++; $display("FAIL full_aempty got=%b want=0", s_aempty); end
    s_ae = 3'd4; #1;
    checks++;
    if (s_aempty !== 1'b1) begin failures++; $display("FAIL ae_thresh_depth got=%b want=1", s_aempty); end
    s_ae = 3'd1;
  endtask

  task automatic test_overflow();
    logic [7:0] rd_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    s_wren = 1; s_wrdata = 8'h55;
    tick();
    s_wren = 0;
    checks++;
    if ({s_level, s_ovf} !== {3'd4, 1'b1}) begin
      failures++; $display("FAIL ovf_set got level=%0d ovf=%b want 4 1", s_level, s_ovf);
    end
    tick();
    checks++;
    if (s_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", s_ovf); end
    for (int i = 0; i < 4; i++) begin
      s_rden = 1;
      tick();
      checks++;
      if ({s_rdvalid, s_rddata, s_level} !== {1'b1, rd_exp[i], 3'(3 - i)}) begin
        failures++;
        $display("FAIL std_read[%0d] got v=%b d=%h lvl=%0d want v=1 d=%h lvl=%0d",
                 i, s_rdvalid, s_rddata, s_level, rd_exp[i], 3 - i);
      end
    end
    s_rden = 0;
    tick();
    checks++;
    if ({s_rdvalid, s_rddata, s_empty} !== {1'b0, 8'h44, 1'b1}) begin
      failures++;
      $display("FAIL std_hold got v=%b d=%h empty=%b want 0 44 1", s_rdvalid, s_rddata, s_empty);
    end
    s_clr = 1;
    tick();
    s_clr = 0;
    checks++;
    if (s_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", s_ovf); end
  endtask

  task automatic test_underflow();
    s_rden = 1;
    tick();
    s_rden = 0;
    checks++;
    if ({s_unf, s_level, s_rdvalid} !== {1'b1, 3'd0, 1'b0}) begin
      failures++; $display("FAIL unf_set got unf=%b lvl=%0d v=%b want 1 0 0", s_unf, s_level, s_rdvalid);
    end
    s_clr = 1;
    tick();
    checks++;
    if (s_unf !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b want=0", s_unf); end
    s_rden = 1;
    tick();
    s_rden = 0; s_clr = 0;
    checks++;
    if (s_unf !== 1'b1) begin failures++; $display("FAIL unf_set_beats_clr got=%b want=1", s_unf); end
    tick();
    checks++;
    if (s_unf !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b want=1", s_unf); end
    s_clr = 1;
    tick();
    s_clr = 0;
    checks++;
    if (s_unf !== 1'b0) begin failures++; $display("FAIL unf_clear2 got=%b want=0", s_unf); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] out_exp [8] = '{8'h90, 8'h91, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    s_wren = 1; s_wrdata = 8'h90; tick();
    s_wrdata = 8'h91; tick();
    for (int i = 0; i < 6; i++) begin
      s_wren = 1; s_rden = 1; s_wrdata = 8'hA0 + 8'(i);
      tick();
      checks++;
      if ({s_level, s_rdvalid, s_rddata} !== {3'd2, 1'b1, out_exp[i]}) begin
        failures++;
        $display("FAIL simul[%0d] got lvl=%0d v=%b d=%h want 2 1 %h", i, s_level, s_rdvalid, s_rddata, out_exp[i]);
      end
    end
    s_wren = 0;
    for (int i = 6; i < 8; i++) begin
      tick();
      checks++;
      if ({s_rdvalid, s_rddata} !== {1'b1, out_exp[i]}) begin
        failures++; $display("FAIL drain[%0d] got v=%b d=%h want 1 %h", i, s_rdvalid, s_rddata, out_exp[i]);
      end
    end
    s_rden = 0;
    tick();
    checks++;
    if ({s_level, s_empty} !== {3'd0, 1'b1}) begin
      failures++; $display("FAIL simul_end got lvl=%0d empty=%b want 0 1", s_level, s_empty);
    end
  endtask

  task automatic test_fwft();
    logic       wr_op [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 1};
    logic       rd_op [10] = '{1, 1, 1, 1, 0, 1, 0, 0, 1, 1};
    logic [2:0] lv_exp [10] = '{4, 4, 3, 2, 3, 3, 4, 5, 4, 4};
    logic [7:0] fr_exp [10] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC4, 8'hD1, 8'hD1, 8'hD1, 8'hD4, 8'hD5};
    logic [7:0] dr_exp [4]  = '{8'hD6, 8'hD7, 8'hD9, 8'h00};
    f_wren = 1; f_wrdata = 8'h7E;
    tick();
    f_wren = 0;
    checks++;
    if ({f_rdvalid, f_rddata, f_level} !== {1'b1, 8'h7E, 3'd1}) begin
      failures++; $display("FAIL fwft_first got v=%b d=%h lvl=%0d want 1 7e 1", f_rdvalid, f_rddata, f_level);
    end
    f_rden = 1;
    tick();
    f_rden = 0;
    checks++;
    if ({f_empty, f_rdvalid, f_rddata} !== {1'b1, 1'b0, 8'h00}) begin
      failures++; $display("FAIL fwft_pop got empty=%b v=%b d=%h want 1 0 00", f_empty, f_rdvalid, f_rddata);
    end
    for (int i = 0; i < 5; i++) begin
      f_wren = 1; f_wrdata = 8'hC0 + 8'(i);
      tick();
    end
    f_wren = 0;
    checks++;
    if ({f_full, f_level, f_rddata, f_afull} !== {1'b1, 3'd5, 8'hC0, 1'b1}) begin
      failures++;
      $display("FAIL fwft_full got full=%b lvl=%0d d=%h af=%b want 1 5 c0 1", f_full, f_level, f_rddata, f_afull);
    end
    for (int i = 0; i < 10; i++) begin
      f_wren = wr_op[i]; f_rden = rd_op[i]; f_wrdata = 8'hD0 + 8'(i);
      tick();
      checks++;
      if ({f_level, f_rddata} !== {lv_exp[i], fr_exp[i]}) begin
        failures++;
        $display("FAIL fwft_mix[%0d] got lvl=%0d d=%h want %0d %h", i, f_level, f_rddata, lv_exp[i], fr_exp[i]);
      end
    end
    f_wren = 0; f_rden = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({f_level, f_rddata} !== {3'(3 - i), dr_exp[i]}) begin
        failures++;
        $display("FAIL fwft_drain[%0d] got lvl=%0d d=%h want %0d %h", i, f_level, f_rddata, 3 - i, dr_exp[i]);
      end
    end
    f_rden = 0;
    checks++;
    if (f_ovf !== 1'b1) begin failures++; $display("FAIL fwft_ovf got=%b want=1", f_ovf); end
  endtask

  task automatic test_mid_reset();
    s_rden = 1; tick(); s_rden = 0;
    for (int i = 0; i < 3; i++) begin
      s_wren = 1; s_wrdata = 8'hB1 + 8'(i);
      tick();
    end
    s_wren = 0;
    f_wren = 1; f_wrdata = 8'hEE; tick(); f_wren = 0;
    checks++;
    if ({s_level, s_unf} !== {3'd3, 1'b1}) begin
      failures++; $display("FAIL pre_reset got lvl=%0d unf=%b want 3 1", s_level, s_unf);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if ({s_level, s_empty, s_aempty, s_rdvalid, s_unf, s_ovf, s_rddata} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL mid_reset got lvl=%0d e=%b ae=%b v=%b unf=%b ovf=%b d=%h want 0 1 1 0 0 0 00",
               s_level, s_empty, s_aempty, s_rdvalid, s_unf, s_ovf, s_rddata);
    end
    checks++;
    if ({f_level, f_rdvalid, f_rddata, f_ovf} !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_fwft got lvl=%0d v=%b d=%h ovf=%b want 0 0 00 0", f_level, f_rdvalid, f_rddata, f_ovf);
    end
    s_wren = 1; s_wrdata = 8'hC5; tick(); s_wren = 0;
    s_rden = 1; tick(); s_rden = 0;
    checks++;
    if ({s_rdvalid, s_rddata, s_level} !== {1'b1, 8'hC5, 3'd0}) begin
      failures++;
      $display("FAIL post_reset_read got v=%b d=%h lvl=%0d want 1 c5 0", s_rdvalid, s_rddata, s_level);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
